uart_tx_arbiter: RTL and testbench

Shares one uart_tx byte transmitter between NUM_CH independent byte-stream requesters, using packet-locked round-robin arbitration.
Generates the transmitter's baud tick (tx_clk) from its tx_clk_en request.
Sequences the transmitter's data_in/data_in_valid/data_in_ready handshake so each byte is handed over exactly once.
Sits between on-chip message sources (status, debug, log channels) and the UART TX pin logic.

---
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart_tx byte transmitter between NUM_CH byte-stream
//            requesters. Whole packets are granted round-robin and stay
//            locked to one channel until the byte flagged last has gone out.
//            Also produces the transmitter's one-cycle baud tick.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   arb_en          : allows new packet grants (an open packet always finishes)
//   req_valid/data/last/ready : per-channel byte handshake, ch i at [8i+7:8i]
//   ut_data/ut_valid/ut_ready : byte handoff to uart_tx
//   ut_clk_en/ut_clk          : baud tick request / one-cycle baud tick
//   grant_id        : currently or last granted channel
//   busy            : high whenever the sequencer is not idle
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int SYSTEM_CLK = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int GAP_BITS   = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      arb_en,
   input  logic [NUM_CH-1:0]         req_valid,
   input  logic [8*NUM_CH-1:0]       req_data,
   input  logic [NUM_CH-1:0]         req_last,
   output logic [NUM_CH-1:0]         req_ready,
   output logic [7:0]                ut_data,
   output logic                      ut_valid,
   input  logic                      ut_ready,
   input  logic                      ut_clk_en,
   output logic                      ut_clk,
   output logic [$clog2(NUM_CH)-1:0] grant_id,
   output logic                      busy
);

   localparam int IDW       = $clog2(NUM_CH);
   localparam int CW        = IDW + 1;
   localparam int N         = SYSTEM_CLK / BAUD_RATE;
   localparam int BAUD_W    = (N > 1) ? $clog2(N) : 1;
   localparam int GAP_TOTAL = GAP_BITS * N;
   localparam int GAP_W     = (GAP_TOTAL > 1) ? $clog2(GAP_TOTAL) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_SEND      = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_GAP       = 3'd5
   } state_t;

   // ------------------------------------------------------------------------
   // Baud tick generator, free of the sequencer
   // ------------------------------------------------------------------------
   logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
   logic              ut_clk_q, ut_clk_d;

   always_comb begin
      baud_cnt_d = '0;
      ut_clk_d   = 1'b0;
      if (ut_clk_en) begin
         if (baud_cnt_q == BAUD_W'(N - 1)) begin
            ut_clk_d   = 1'b1;
            baud_cnt_d = '0;
         end else begin
            baud_cnt_d = baud_cnt_q + BAUD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt_q <= '0;
         ut_clk_q   <= 1'b0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         ut_clk_q   <= ut_clk_d;
      end
   end

   assign ut_clk = ut_clk_q;

   // ------------------------------------------------------------------------
   // Round-robin pick: first valid channel after the last packet's owner
   // ------------------------------------------------------------------------
   state_t            state_q;
   logic [IDW-1:0]    grant_q;
   logic [IDW-1:0]    ptr_q;
   logic [7:0]        data_q;
   logic              last_q;
   logic [GAP_W-1:0]  gap_cnt_q;

   logic [IDW-1:0]    pick_id;
   logic              pick_vld;
   logic [CW-1:0]     scan_idx;

   always_comb begin
      pick_id  = '0;
      pick_vld = 1'b0;
      scan_idx = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         scan_idx = {1'b0, ptr_q} + CW'(k);
         if (scan_idx >= CW'(NUM_CH)) begin
            scan_idx = scan_idx - CW'(NUM_CH);
         end
         if (!pick_vld && req_valid[scan_idx[IDW-1:0]]) begin
            pick_id  = scan_idx[IDW-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   // Byte of the granted channel; grant_q*8 as a concatenation keeps widths exact
   logic [7:0] sel_data;
   assign sel_data = req_data[{grant_q, 3'b000} +: 8];

   always_comb begin
      req_ready = '0;
      if (state_q == S_LOAD) begin
         req_ready[grant_q] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Packet sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= IDW'(NUM_CH - 1);
         data_q    <= '0;
         last_q    <= 1'b0;
         gap_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arb_en && pick_vld) begin
                  grant_q <= pick_id;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Packet lock: only the granted channel is ever looked at here
               if (req_valid[grant_q]) begin
                  data_q  <= sel_data;
                  last_q  <= req_last[grant_q];
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (ut_ready) begin
                  state_q <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               // The transmitter drops ready once it has taken the byte
               if (!ut_ready) begin
                  state_q <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (ut_ready) begin
                  if (last_q) begin
                     ptr_q     <= grant_q;
                     gap_cnt_q <= '0;
                     state_q   <= (GAP_TOTAL == 0) ? S_IDLE : S_GAP;
                  end else begin
                     state_q <= S_LOAD;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_W'(GAP_TOTAL - 1)) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Decoded straight from the state register, so no combinational input paths
   assign ut_valid = (state_q == S_SEND);
   assign busy     = (state_q != S_IDLE);
   assign ut_data  = data_q;
   assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter with N = 16
//            clk per bit (160 Hz / 10 baud), GAP_BITS = 1, four channels.
//            Requesters are FIFO-fed byte sources; the transmitter is a small
//            model that drops ready for four cycles after each byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NCH  = 4;
   localparam int SYS  = 160;
   localparam int BAUD = 10;
   localparam int GAPB = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              arb_en = 1'b0;
   logic [NCH-1:0]    req_valid = '0;
   logic [8*NCH-1:0]  req_data = '0;
   logic [NCH-1:0]    req_last = '0;
   logic [NCH-1:0]    req_ready;
   logic [7:0]        ut_data;
   logic              ut_valid;
   logic              ut_ready = 1'b1;
   logic              ut_clk_en = 1'b0;
   logic              ut_clk;
   logic [1:0]        grant_id;
   logic              busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_CH     (NCH),
      .SYSTEM_CLK (SYS),
      .BAUD_RATE  (BAUD),
      .GAP_BITS   (GAPB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arb_en    (arb_en),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .ut_data   (ut_data),
      .ut_valid  (ut_valid),
      .ut_ready  (ut_ready),
      .ut_clk_en (ut_clk_en),
      .ut_clk    (ut_clk),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-channel source FIFOs: {last, data}
   logic [8:0] src_mem [NCH][16];
   int         src_wr  [NCH];
   int         src_rd  [NCH];
   int         rr_cnt  [NCH];
   int         uv_cnt = 0;

   // Bytes accepted by the transmitter model, in order
   logic [7:0] log_data [64];
   logic [1:0] log_ch   [64];
   int         log_n = 0;
   int         ucnt  = 0;

   task automatic push(input int ch, input logic last, input logic [7:0] d);
      src_mem[ch][src_wr[ch] % 16] = {last, d};
      src_wr[ch]++;
   endtask

   task automatic flush_sources();
      for (int c = 0; c < NCH; c++) src_rd[c] = src_wr[c];
   endtask

   task automatic wait_log(input int n, input int budget);
      int b = budget;
      while (log_n < n && b > 0) begin
         @(negedge clk);
         b--;
      end
      check("wait_log", log_n, n);
   endtask

   task automatic wait_idle(input int budget);
      int b = budget;
      while (busy && b > 0) begin
         @(negedge clk);
         b--;
      end
      check("wait_idle", busy, 0);
   endtask

   // Requester sources plus cycle monitors (pre-edge values)
   initial begin
      for (int c = 0; c < NCH; c++) begin
         src_wr[c] = 0; src_rd[c] = 0; rr_cnt[c] = 0;
      end
      forever begin
         @(posedge clk);
         for (int c = 0; c < NCH; c++) begin
            if (req_ready[c]) rr_cnt[c]++;
            if (rst_n && req_valid[c] && req_ready[c]) src_rd[c]++;
         end
         if (ut_valid) uv_cnt++;
         #1;
         for (int c = 0; c < NCH; c++) begin
            if (src_rd[c] != src_wr[c]) begin
               req_valid[c]       = 1'b1;
               req_data[8*c +: 8] = src_mem[c][src_rd[c] % 16][7:0];
               req_last[c]        = src_mem[c][src_rd[c] % 16][8];
            end else begin
               req_valid[c] = 1'b0;
               req_last[c]  = 1'b0;
            end
         end
      end
   end

   // Transmitter model: takes a byte on valid&ready, then is busy 4 cycles
   initial begin
      forever begin
         @(posedge clk);
         if (ut_valid && ut_ready) begin
            log_ch[log_n]   = grant_id;
            log_data[log_n] = ut_data;
            log_n++;
            ucnt = 4;
         end
         #1;
         if (ucnt > 0) begin
            ut_ready = 1'b0;
            ucnt--;
         end else begin
            ut_ready = 1'b1;
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush_sources();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_req_ready"}, req_ready, 0);
      check({pfx, "_ut_data"},   ut_data,   0);
      check({pfx, "_ut_valid"},  ut_valid,  0);
      check({pfx, "_ut_clk"},    ut_clk,    0);
      check({pfx, "_grant_id"},  grant_id,  0);
      check({pfx, "_busy"},      busy,      0);
   endtask

   int         base, cnt, rr0, uv0, npulse, first, hi;
   int         pulse [3];
   logic [1:0] exp_ch [5];
   logic [7:0] exp_d  [5];

   initial begin
      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n  = 1'b1;
      arb_en = 1'b1;

      // ---------------- single byte ----------------
      @(negedge clk);
      rr0 = rr_cnt[0];
      uv0 = uv_cnt;
      push(0, 1'b1, 8'hA5);
      wait_log(1, 100);
      check("single_ch",   log_ch[0],   0);
      check("single_data", log_data[0], 8'hA5);
      cnt = 0;
      while (!ut_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      // busy spans the cycle where ready is first sampled plus 16 gap cycles
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("single_gap_cycles",   cnt, 17);
      check("single_ready_cycles", rr_cnt[0] - rr0, 1);
      check("single_valid_cycles", uv_cnt - uv0, 1);
      check("single_data_hold",    ut_data, 8'hA5);

      // ---------------- round robin ----------------
      apply_reset();
      @(negedge clk);
      base = log_n;
      push(0, 1'b1, 8'h10);
      push(1, 1'b1, 8'h21);
      push(2, 1'b1, 8'h32);
      push(3, 1'b1, 8'h43);
      push(0, 1'b1, 8'h50);
      exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_d  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h50};
      wait_log(base + 5, 400);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rr_%0d", k), {log_ch[base+k], log_data[base+k]},
               {exp_ch[k], exp_d[k]});
      end

      // ---------------- packet lock ----------------
      wait_idle(100);
      @(negedge clk);
      base = log_n;
      push(1, 1'b0, 8'h01);
      push(1, 1'b0, 8'h02);
      push(1, 1'b1, 8'h03);
      push(0, 1'b1, 8'hE0);
      push(2, 1'b1, 8'hE2);
      exp_ch = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
      exp_d  = '{8'h01, 8'h02, 8'h03, 8'hE2, 8'hE0};
      wait_log(base + 5, 400);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("lock_%0d", k), {log_ch[base+k], log_data[base+k]},
               {exp_ch[k], exp_d[k]});
      end

      // ---------------- baud tick ----------------
      wait_idle(100);
      @(negedge clk);
      ut_clk_en = 1'b1;
      npulse = 0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (ut_clk) begin
            if (npulse < 3) pulse[npulse] = k;
            npulse++;
         end
      end
      check("baud_pulses", npulse, 3);
      check("baud_p0", pulse[0], 16);
      check("baud_p1", pulse[1], 32);
      check("baud_p2", pulse[2], 48);
      ut_clk_en = 1'b0;
      hi = 0;
      repeat (8) begin
         @(negedge clk);
         if (ut_clk) hi++;
      end
      check("baud_off", hi, 0);
      ut_clk_en = 1'b1;
      first = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ut_clk && first == 0) first = k;
      end
      check("baud_reenable", first, 16);
      ut_clk_en = 1'b0;

      // ---------------- arb_en drop mid-packet ----------------
      @(negedge clk);
      base = log_n;
      push(2, 1'b0, 8'hC1);
      push(2, 1'b1, 8'hC2);
      wait_log(base + 1, 200);
      push(0, 1'b1, 8'hD0);
      push(3, 1'b1, 8'hD3);
      arb_en = 1'b0;
      wait_log(base + 2, 200);
      wait_idle(200);
      repeat (40) @(negedge clk);
      check("arboff_no_grant", log_n, base + 2);
      check("arboff_busy",     busy, 0);
      check("arboff_ready",    req_ready, 0);
      check("arboff_b0", {log_ch[base], log_data[base]},     {2'd2, 8'hC1});
      check("arboff_b1", {log_ch[base+1], log_data[base+1]}, {2'd2, 8'hC2});
      arb_en = 1'b1;
      wait_log(base + 4, 300);
      check("arbon_first",  {log_ch[base+2], log_data[base+2]}, {2'd3, 8'hD3});
      check("arbon_second", {log_ch[base+3], log_data[base+3]}, {2'd0, 8'hD0});

      // ---------------- reset mid-packet ----------------
      wait_idle(100);
      @(negedge clk);
      ut_clk_en = 1'b1;
      base = log_n;
      push(3, 1'b0, 8'h31);
      push(3, 1'b1, 8'h32);
      wait_log(base + 1, 200);
      @(negedge clk);
      check("midrst_busy_pre",  busy, 1);
      check("midrst_grant_pre", grant_id, 3);
      check("midrst_data_pre",  ut_data, 8'h31);
      rst_n = 1'b0;
      flush_sources();
      #1;
      check_reset_values("midrst");
      push(3, 1'b1, 8'h77);
      push(0, 1'b1, 8'h66);
      repeat (3) @(negedge clk);
      rst_n     = 1'b1;
      ut_clk_en = 1'b0;
      wait_log(base + 3, 300);
      check("midrst_first",  {log_ch[base+1], log_data[base+1]}, {2'd0, 8'h66});
      check("midrst_second", {log_ch[base+2], log_data[base+2]}, {2'd3, 8'h77});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
